// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the async FIFO write side (wclk domain).
// Grants are combinational with zero latency, and every write is gated by wfull.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DSIZE     = 8,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic                      wclk,
    input  logic                      wrst_n,
    input  logic                      arb_en,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DSIZE-1:0]     req_data,
    input  logic                      wfull,
    output logic [NREQ-1:0]           gnt,
    output logic                      winc,
    output logic [DSIZE-1:0]          wdata,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam int PW = $clog2(NREQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e            state_q,     state_d;
    logic [PW-1:0]     rr_ptr_q,    rr_ptr_d;
    logic [PW-1:0]     owner_q,     owner_d;
    logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [PW-1:0]     cand_s;
    logic              cand_vld_s;
    logic [PW-1:0]     sel_s;
    logic              wr_s;
    logic              stall_s;

    function automatic logic [PW-1:0] idx_add(input logic [PW-1:0] base, input int off);
        return PW'((int'(base) + off) % NREQ);
    endfunction

    // Candidate search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        cand_s     = rr_ptr_q;
        cand_vld_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!cand_vld_s && req[idx_add(rr_ptr_q, i)]) begin
                cand_vld_s = 1'b1;
                cand_s     = idx_add(rr_ptr_q, i);
            end else begin
                cand_vld_s = cand_vld_s;
            end
        end
    end

    // Next-state, write decision and stall accounting.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        stall_cnt_d = stall_cnt_q;
        sel_s       = owner_q;
        wr_s        = 1'b0;
        stall_s     = 1'b0;
        case (state_q)
            IDLE: begin
                sel_s = cand_s;
                if (arb_en && cand_vld_s && !wfull) begin
                    wr_s    = 1'b1;
                    owner_d = cand_s;
                    if (MAX_BURST == 1) begin
                        rr_ptr_d = idx_add(cand_s, 1);
                    end else begin
                        state_d     = BURST;
                        burst_cnt_d = BW'(1);
                    end
                end else begin
                    stall_s = arb_en && wfull && cand_vld_s;
                end
            end
            BURST: begin
                // A dropped request ends the burst even while stalled or disabled.
                if (!req[owner_q]) begin
                    state_d     = IDLE;
                    rr_ptr_d    = idx_add(owner_q, 1);
                    burst_cnt_d = BW'(0);
                end else if (arb_en && !wfull) begin
                    wr_s = 1'b1;
                    if (burst_cnt_q == BW'(MAX_BURST - 1)) begin
                        state_d     = IDLE;
                        rr_ptr_d    = idx_add(owner_q, 1);
                        burst_cnt_d = BW'(0);
                    end else begin
                        burst_cnt_d = burst_cnt_q + BW'(1);
                    end
                end else begin
                    stall_s = arb_en && wfull;
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = BW'(0);
            end
        endcase
        if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Write-port drive; forced quiet while reset is asserted.
    always_comb begin
        gnt   = '0;
        winc  = 1'b0;
        wdata = '0;
        if (wrst_n && wr_s) begin
            gnt[sel_s] = 1'b1;
            winc       = 1'b1;
            wdata      = req_data[int'(sel_s) * DSIZE +: DSIZE];
        end else begin
            winc = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign busy      = (state_q == BURST);
    assign owner     = owner_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter checked against a behavioural arbitration model
// and a small FIFO scoreboard.
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int DSIZE     = 8;
    localparam int MB        = 4;
    localparam int CNT_W     = 10;
    localparam int STALL_MAX = (1 << CNT_W) - 1;
    localparam int DEPTH     = 8;

    logic                    wclk = 1'b0;
    logic                    wrst_n;
    logic                    arb_en;
    logic [NREQ-1:0]         req;
    logic [NREQ*DSIZE-1:0]   req_data;
    logic                    wfull;
    logic [NREQ-1:0]         gnt;
    logic                    winc;
    logic [DSIZE-1:0]        wdata;
    logic                    busy;
    logic [$clog2(NREQ)-1:0] owner;
    logic [CNT_W-1:0]        stall_cnt;

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(MB), .CNT_W(CNT_W)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .arb_en(arb_en), .req(req), .req_data(req_data),
        .wfull(wfull), .gnt(gnt), .winc(winc), .wdata(wdata), .busy(busy),
        .owner(owner), .stall_cnt(stall_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: ownership mode, owner, writes in current burst, priority pointer.
    bit              m_busy;
    int              m_owner, m_cnt, m_ptr, m_stall;
    logic [NREQ-1:0] m_last_gnt;
    int              q_exp[$];
    int              q_dut[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_stall = 0; m_last_gnt = '0;
    endtask

    task automatic step(input logic en, input logic [NREQ-1:0] r, input logic full);
        int cand;
        logic [NREQ-1:0] exp_gnt;
        logic [DSIZE-1:0] exp_wd;
        bit waiting;
        @(negedge wclk);
        arb_en = en; req = r; wfull = full;
        for (int i = 0; i < NREQ; i++) req_data[i*DSIZE +: DSIZE] = DSIZE'($urandom);
        #1;
        cand = -1;
        if (en && !full) begin
            if (!m_busy) begin
                for (int j = 0; j < NREQ; j++)
                    if (cand < 0 && r[(m_ptr + j) % NREQ]) cand = (m_ptr + j) % NREQ;
            end else if (r[m_owner]) begin
                cand = m_owner;
            end
        end
        exp_gnt = (cand >= 0) ? NREQ'(1 << cand) : '0;
        exp_wd  = (cand >= 0) ? req_data[cand*DSIZE +: DSIZE] : '0;
        chk("gnt", 32'(gnt), 32'(exp_gnt));
        chk("winc", 32'(winc), 32'(cand >= 0));
        chk("wdata", 32'(wdata), 32'(exp_wd));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("owner", 32'(owner), 32'(m_owner));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("winc_while_full", 32'(winc & wfull), 32'd0);
        if (cand >= 0) q_exp.push_back(int'(exp_wd));
        if (winc) q_dut.push_back(int'(wdata));
        m_last_gnt = exp_gnt;
        // Model update for the coming edge.
        waiting = m_busy ? r[m_owner] : (r != '0);
        if (en && full && waiting && m_stall < STALL_MAX) m_stall++;
        if (!m_busy) begin
            if (cand >= 0) begin
                m_owner = cand;
                if (MB == 1) m_ptr = (cand + 1) % NREQ;
                else begin m_busy = 1'b1; m_cnt = 1; end
            end
        end else if (!r[m_owner]) begin
            m_busy = 1'b0; m_ptr = (m_owner + 1) % NREQ; m_cnt = 0;
        end else if (cand >= 0) begin
            m_cnt++;
            if (m_cnt == MB) begin m_busy = 1'b0; m_ptr = (m_owner + 1) % NREQ; m_cnt = 0; end
        end
    endtask

    function automatic logic [NREQ-1:0] next_req(input logic [NREQ-1:0] cur);
        logic [NREQ-1:0] nr;
        for (int i = 0; i < NREQ; i++) begin
            if (m_last_gnt[i])  nr[i] = 1'($urandom_range(0, 1));
            else if (cur[i])    nr[i] = ($urandom_range(0, 19) != 0);
            else                nr[i] = 1'($urandom_range(0, 1));
        end
        return nr;
    endfunction

    initial begin
        logic [NREQ-1:0] r;
        int a, b;
        wrst_n = 1'b0; arb_en = 1'b1; req = 4'b1111; wfull = 1'b0;
        req_data = 32'hA5A5_5A5A;
        model_reset();
        #12;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_winc", 32'(winc), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        arb_en = 1'b0; req = '0;
        @(negedge wclk); wrst_n = 1'b1;

        // Single requester, then all four continuously.
        repeat (10) step(1'b1, 4'b0100, 1'b0);
        repeat (20) step(1'b1, 4'b1111, 1'b0);
        // Backpressure mid-burst.
        repeat (2) step(1'b1, 4'b1111, 1'b0);
        repeat (5) step(1'b1, 4'b1111, 1'b1);
        repeat (8) step(1'b1, 4'b1111, 1'b0);
        // Owner drops its request after two writes, then enable-low hold.
        repeat (2) step(1'b1, 4'b1111, 1'b0);
        step(1'b1, 4'b1111 & ~NREQ'(1 << m_owner), 1'b0);
        repeat (3) step(1'b1, 4'b1111, 1'b0);
        repeat (3) step(1'b0, 4'b1111, 1'b0);
        repeat (3) step(1'b1, 4'b1111, 1'b0);

        // Asynchronous reset between edges while a burst is writing.
        @(negedge wclk); #2;
        wrst_n = 1'b0; #1;
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_winc", 32'(winc), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_owner", 32'(owner), 32'd0);
        model_reset();
        arb_en = 1'b0; req = '0;
        @(negedge wclk); wrst_n = 1'b1;
        step(1'b1, 4'b0110, 1'b0);
        repeat (6) step(1'b1, 4'b0110, 1'b0);

        // Random traffic with random backpressure.
        r = '0;
        for (int k = 0; k < 3000; k++) begin
            r = next_req(r);
            step(($urandom_range(0, 9) != 0), r, ($urandom_range(0, 4) == 0));
        end

        // FIFO fill with reads stopped, then random draining.
        q_exp.delete(); q_dut.delete();
        for (int k = 0; k < 400; k++) begin
            if (k >= 100 && q_dut.size() > 0 && $urandom_range(0, 2) == 0) begin
                a = q_dut.pop_front();
                b = (q_exp.size() > 0) ? q_exp.pop_front() : -1;
                chk("fifo_data", 32'(a), 32'(b));
            end
            r = next_req(r);
            step(1'b1, r, (q_dut.size() >= DEPTH));
        end
        chk("fifo_len", 32'(q_dut.size()), 32'(q_exp.size()));
        while (q_dut.size() > 0) begin
            a = q_dut.pop_front();
            b = (q_exp.size() > 0) ? q_exp.pop_front() : -1;
            chk("fifo_drain", 32'(a), 32'(b));
        end

        // Long stall drives the counter into saturation.
        repeat (STALL_MAX + 50) step(1'b1, 4'b1111, 1'b1);
        chk("stall_sat", 32'(stall_cnt), 32'(STALL_MAX));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
